oam_dma: RTL

Sprite (OAM) DMA engine for the 2A03, on the system bus beside `cpu_2a03`. It watches CPU writes to $4014 and latches the written value as a source page. It then halts the CPU and takes the bus, copying 256 bytes from $PP00–$PPFF to OAMDATA ($2004) as alternating read/write cycles. When the copy is done it releases the bus and the CPU resumes.

---
 rtl/oam_dma_pkg.sv | 29 ++
 rtl/oam_dma_if.sv | 30 +++
 rtl/apu_cycle_parity.sv | 21 ++
 rtl/oam_dma.sv | 115 +++++++++++
 4 files changed

// File: rtl/oam_dma_pkg.sv
// oam_dma_pkg: shared definitions for the sprite (OAM) DMA engine.
//   - dma_state_t : 3-bit state encodings (IDLE, HALT, ALIGN, READ, WRITE)
//   - DMA_REG_ADDR_DEFAULT / OAM_DATA_ADDR_DEFAULT : default trigger and
//     destination addresses
//   - RW_READ / RW_WRITE : bus direction encodings, same values as the CPU uses
//   - src_addr() : forms the source address from page and index
package oam_dma_pkg;

  typedef enum logic [2:0] {
    DMA_STATE_IDLE  = 3'd0,
    DMA_STATE_HALT  = 3'd1,
    DMA_STATE_ALIGN = 3'd2,
    DMA_STATE_READ  = 3'd3,
    DMA_STATE_WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR_DEFAULT  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEFAULT = 16'h2004;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Page byte is fixed for the whole copy; the index never carries into it.
  function automatic logic [15:0] src_addr(input logic [7:0] page,
                                           input logic [7:0] idx);
    return {page, idx};
  endfunction

endpackage

// File: rtl/oam_dma_if.sv
// oam_dma_if: system-bus signals seen by the OAM DMA engine.
//   cpu_addr/cpu_wdata/cpu_rw : CPU bus outputs (watched for the trigger write)
//   bus_rdata                 : system data bus, read direction
//   cpu_halt                  : 1 = CPU must freeze this cycle
//   bus_own                   : 1 = bus is driven from the dma_* signals
//   dma_addr/dma_rw/dma_wdata : DMA bus request
// master = the DMA engine, slave = the system side (CPU, bus mux, memory).
interface oam_dma_if;

  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rw;
  logic [7:0]  bus_rdata;
  logic        cpu_halt;
  logic        bus_own;
  logic [15:0] dma_addr;
  logic        dma_rw;
  logic [7:0]  dma_wdata;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_rw, bus_rdata,
    output cpu_halt, bus_own, dma_addr, dma_rw, dma_wdata
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_rw, bus_rdata,
    input  cpu_halt, bus_own, dma_addr, dma_rw, dma_wdata
  );

endinterface

// File: rtl/apu_cycle_parity.sv
// apu_cycle_parity: free-running get/put cycle toggle shared by the APU
// frame counter and the DMA engines.
//   clock  : system clock (CPU cycle rate)
//   nreset : synchronous, active-high reset
//   phase  : 0 on get cycles, 1 on put cycles; 0 in the cycle after reset
module apu_cycle_parity (
  input  logic clock,
  input  logic nreset,
  output logic phase
);

  // Toggle every cycle; reset restarts on a get cycle.
  always_ff @(posedge clock) begin
    if (nreset) begin
      phase <= 1'b0;
    end else begin
      phase <= ~phase;
    end
  end

endmodule

// File: rtl/oam_dma.sv
// oam_dma: sprite DMA engine. A CPU write to DMA_REG_ADDR latches a source
// page, halts the CPU and copies $PP00-$PPFF to OAM_DATA_ADDR as alternating
// read (get cycle) / write (put cycle) pairs, then releases the bus.
//   clock  : system clock (CPU cycle rate)
//   nreset : synchronous, active-high reset
//   bus    : oam_dma_if master modport (CPU watch inputs, DMA bus outputs)
// All outputs are decoded from registered state only; cpu_* inputs never
// reach an output combinationally.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEFAULT,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEFAULT
) (
  input  logic     clock,
  input  logic     nreset,
  oam_dma_if.master bus
);

  dma_state_t state;
  dma_state_t state_next;
  logic [7:0] page;
  logic [7:0] page_next;
  logic [7:0] idx;
  logic [7:0] idx_next;
  logic [7:0] latch;
  logic [7:0] latch_next;
  logic       phase;

  apu_cycle_parity u_parity (
    .clock  (clock),
    .nreset (nreset),
    .phase  (phase)
  );

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (nreset) begin
      state <= DMA_STATE_IDLE;
      page  <= 8'h00;
      idx   <= 8'h00;
      latch <= 8'h00;
    end else begin
      state <= state_next;
      page  <= page_next;
      idx   <= idx_next;
      latch <= latch_next;
    end
  end

  // Next-state logic and output decode.
  always_comb begin
    state_next    = state;
    page_next     = page;
    idx_next      = idx;
    latch_next    = latch;
    bus.cpu_halt  = 1'b0;
    bus.bus_own   = 1'b0;
    bus.dma_addr  = 16'h0000;
    bus.dma_rw    = RW_READ;
    bus.dma_wdata = 8'h00;

    case (state)
      DMA_STATE_IDLE: begin
        // The trigger is only honoured here, so page stays fixed mid-copy.
        if (bus.cpu_rw == RW_WRITE && bus.cpu_addr == DMA_REG_ADDR) begin
          page_next  = bus.cpu_wdata;
          idx_next   = 8'h00;
          state_next = DMA_STATE_HALT;
        end else begin
          state_next = DMA_STATE_IDLE;
        end
      end
      DMA_STATE_HALT: begin
        bus.cpu_halt = 1'b1;
        // Reads must land on get cycles (phase 0); phase 1 now means the
        // next cycle is a get cycle.
        if (phase) begin
          state_next = DMA_STATE_READ;
        end else begin
          state_next = DMA_STATE_ALIGN;
        end
      end
      DMA_STATE_ALIGN: begin
        bus.cpu_halt = 1'b1;
        state_next   = DMA_STATE_READ;
      end
      DMA_STATE_READ: begin
        bus.cpu_halt = 1'b1;
        bus.bus_own  = 1'b1;
        bus.dma_addr = src_addr(page, idx);
        bus.dma_rw   = RW_READ;
        latch_next   = bus.bus_rdata;
        state_next   = DMA_STATE_WRITE;
      end
      DMA_STATE_WRITE: begin
        bus.cpu_halt  = 1'b1;
        bus.bus_own   = 1'b1;
        bus.dma_addr  = OAM_DATA_ADDR;
        bus.dma_rw    = RW_WRITE;
        bus.dma_wdata = latch;
        idx_next      = idx + 8'd1;
        if (idx == 8'hFF) begin
          state_next = DMA_STATE_IDLE;
        end else begin
          state_next = DMA_STATE_READ;
        end
      end
      default: begin
        state_next = DMA_STATE_IDLE;
      end
    endcase
  end

endmodule
